// File: rtl/keypad_scan16.sv
// keypad_scan16: 4x4 keypad row scanner with frame-level debounce and an ack handshake.
// Macro KEYPAD_SCAN16_DEBOUNCE_EN enables multi-frame qualification (QUAL state).
module keypad_scan16 #(
  parameter int ROW_DWELL      = 4,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  col,
  output logic [3:0]  row,
  output logic [15:0] out,
  output logic        valid,
  input  logic        ack
);

  localparam logic [7:0] LP_LAST_DWELL = 8'(ROW_DWELL - 1);

`ifdef KEYPAD_SCAN16_DEBOUNCE_EN
  localparam logic [3:0] LP_DEBOUNCE = 4'(DEBOUNCE_SCANS);
  typedef enum logic [1:0] {IDLE = 2'd0, QUAL = 2'd1, HELD = 2'd2, WAITREL = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, HELD = 2'd2, WAITREL = 2'd3} state_t;
`endif

  logic [7:0]  r_dwell;
  logic [1:0]  r_rowIdx;
  logic [3:0]  r_row;
  logic [11:0] r_frame;
  logic [15:0] r_out;
  logic        r_valid;
  state_t      r_state;
`ifdef KEYPAD_SCAN16_DEBOUNCE_EN
  logic [15:0] r_cand;
  logic [3:0]  r_count;
`endif

  logic        w_sample;
  logic        w_frameDone;
  logic [15:0] w_frame;
  logic        w_single;
  logic        w_release;

  // Row 3 is never stored: the completed frame takes its nibble straight from col.
  assign w_sample    = (r_dwell == LP_LAST_DWELL);
  assign w_frameDone = w_sample && (r_rowIdx == 2'd3);
  assign w_frame     = {col, r_frame};
  assign w_single    = (w_frame != 16'h0000) && ((w_frame & (w_frame - 16'h0001)) == 16'h0000);
  assign w_release   = (w_frame == 16'h0000);

  assign row   = r_row;
  assign out   = r_out;
  assign valid = r_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dwell  <= 8'd0;
      r_rowIdx <= 2'd0;
      r_row    <= 4'b0001;
      r_frame  <= 12'h000;
    end else if (w_sample) begin
      r_dwell  <= 8'd0;
      r_rowIdx <= r_rowIdx + 2'd1;
      r_row    <= {r_row[2:0], r_row[3]};
      case (r_rowIdx)
        2'd0:    r_frame[3:0]  <= col;
        2'd1:    r_frame[7:4]  <= col;
        2'd2:    r_frame[11:8] <= col;
        default: ;
      endcase
    end else begin
      r_dwell <= r_dwell + 8'd1;
    end
  end

  // Capture loads out and valid on the same frame-completing edge that enters HELD.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_out   <= 16'h0000;
      r_valid <= 1'b0;
`ifdef KEYPAD_SCAN16_DEBOUNCE_EN
      r_cand  <= 16'h0000;
      r_count <= 4'd0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_frameDone && w_single) begin
`ifdef KEYPAD_SCAN16_DEBOUNCE_EN
            if (LP_DEBOUNCE <= 4'd1) begin
              r_out   <= w_frame;
              r_valid <= 1'b1;
              r_state <= HELD;
            end else begin
              r_cand  <= w_frame;
              r_count <= 4'd1;
              r_state <= QUAL;
            end
`else
            r_out   <= w_frame;
            r_valid <= 1'b1;
            r_state <= HELD;
`endif
          end
        end
`ifdef KEYPAD_SCAN16_DEBOUNCE_EN
        QUAL: begin
          if (w_frameDone) begin
            if (w_frame == r_cand) begin
              if (r_count + 4'd1 >= LP_DEBOUNCE) begin
                r_out   <= r_cand;
                r_valid <= 1'b1;
                r_count <= 4'd0;
                r_state <= HELD;
              end else begin
                r_count <= r_count + 4'd1;
              end
            end else begin
              r_count <= 4'd0;
              r_state <= IDLE;
            end
          end
        end
`endif
        HELD: begin
          if (ack) begin
            r_out   <= 16'h0000;
            r_valid <= 1'b0;
            r_state <= WAITREL;
          end
        end
        WAITREL: begin
          if (w_frameDone && w_release) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
